// File: rtl/digest_hex_tx.sv
// Streams a captured hash digest to uart_tx as lowercase ASCII hex, MSB nibble first,
// optionally followed by CR/LF, so the terminal output matches the openssl digest format.
module digest_hex_tx #(
    parameter int DIGEST_BITS = 256,
    parameter bit APPEND_CRLF = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DIGEST_BITS-1:0] digest,
    input  logic                   digest_valid,
    output logic                   busy,
    output logic                   done,
    output logic [7:0]             tx_data,
    output logic                   tx_data_ready,
    input  logic                   tx_busy
);

    localparam int HEX_N  = DIGEST_BITS / 4;
    localparam int CHAR_N = HEX_N + (APPEND_CRLF ? 2 : 0);
    localparam int CNT_W  = $clog2(CHAR_N + 1);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CHAR_N - 1);
    localparam logic [CNT_W-1:0] HEX_LAST = CNT_W'(HEX_N - 1);
    localparam logic [CNT_W-1:0] CR_IDX   = CNT_W'(HEX_N);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SEND    = 2'd1;
    localparam logic [1:0] S_WAIT_HI = 2'd2;
    localparam logic [1:0] S_WAIT_LO = 2'd3;

    logic [1:0]             r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [DIGEST_BITS-1:0] r_shift;
    logic                   r_busy;
    logic                   r_done;
    logic [7:0]             r_tx_data;

    logic [3:0] w_nibble;
    logic [7:0] w_char;
    logic       w_req;

    assign w_nibble = r_shift[DIGEST_BITS-1 -: 4];

    // NOTE: every branch assigns w_char, so this stays purely combinational (no latch).
    always_comb begin
        w_char = 8'h0a;
        if (r_cnt <= HEX_LAST) begin
            w_char = (w_nibble < 4'd10) ? (8'h30 + {4'h0, w_nibble})
                                        : (8'h57 + {4'h0, w_nibble});
        end else if (r_cnt == CR_IDX) begin
            w_char = 8'h0d;
        end
    end

    // NOTE: the request is decoded from state and tx_busy, giving one-cycle start latency
    // while tx_data can only move on the cycle uart_tx is actually sampling it.
    assign w_req         = (r_state == S_SEND) && !tx_busy;
    assign tx_data_ready = w_req;
    assign tx_data       = w_req ? w_char : r_tx_data;
    assign busy          = r_busy;
    assign done          = r_done;

    // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_shift   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_tx_data <= 8'h00;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (digest_valid) begin
                        r_shift <= digest;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (!tx_busy) begin
                        r_tx_data <= w_char;
                        r_state   <= S_WAIT_HI;
                    end
                end
                S_WAIT_HI: begin
                    if (tx_busy) begin
                        r_state <= S_WAIT_LO;
                    end
                end
                S_WAIT_LO: begin
                    if (!tx_busy) begin
                        if (r_cnt == LAST_IDX) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                            if (r_cnt < HEX_LAST) begin
                                r_shift <= r_shift << 4;
                            end
                            r_state <= S_SEND;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_digest_hex_tx.sv
// Directed bench for digest_hex_tx: three configurations, each driving a uart_tx model
// that stays busy for 10 cycles per accepted byte.
module tb_digest_hex_tx;

    localparam string HEX_D = "3a985da74fe225b2045c172d6bd390bd855f086e3e9d525b46bfe24511431532";
    localparam logic [255:0] DIG_D =
        256'h3a985da74fe225b2045c172d6bd390bd855f086e3e9d525b46bfe24511431532;

    logic         clk;
    logic         rst_n;
    logic [255:0] digest;
    logic [2:0]   dv;
    logic [2:0]   busy;
    logic [2:0]   done;
    logic [2:0]   rdy;
    logic [2:0]   tx_busy;
    logic [2:0]   hold;
    logic [7:0]   tx_data [3];
    logic         clr;

    int tests = 0;
    int fails = 0;

    // uart model and monitor state
    int         cyc = 0;
    int         busy_cnt [3] = '{0, 0, 0};
    int         rx_cnt   [3] = '{0, 0, 0};
    int         done_cnt [3] = '{0, 0, 0};
    int         viol     [3] = '{0, 0, 0};
    int         lat_err  [3] = '{0, 0, 0};
    int         fall_cyc [3] = '{0, 0, 0};
    logic [7:0] prev_data [3] = '{8'h00, 8'h00, 8'h00};
    logic [2:0] prev_tb = 3'b000;
    logic [7:0] rx_mem [3][128];

    // 256-bit, CRLF
    digest_hex_tx #(.DIGEST_BITS(256), .APPEND_CRLF(1'b1)) u_a (
        .clk(clk), .rst_n(rst_n), .digest(digest), .digest_valid(dv[0]),
        .busy(busy[0]), .done(done[0]), .tx_data(tx_data[0]),
        .tx_data_ready(rdy[0]), .tx_busy(tx_busy[0]));

    // 256-bit, hex only
    digest_hex_tx #(.DIGEST_BITS(256), .APPEND_CRLF(1'b0)) u_b (
        .clk(clk), .rst_n(rst_n), .digest(digest), .digest_valid(dv[1]),
        .busy(busy[1]), .done(done[1]), .tx_data(tx_data[1]),
        .tx_data_ready(rdy[1]), .tx_busy(tx_busy[1]));

    // 8-bit, CRLF
    digest_hex_tx #(.DIGEST_BITS(8), .APPEND_CRLF(1'b1)) u_c (
        .clk(clk), .rst_n(rst_n), .digest(digest[7:0]), .digest_valid(dv[2]),
        .busy(busy[2]), .done(done[2]), .tx_data(tx_data[2]),
        .tx_data_ready(rdy[2]), .tx_busy(tx_busy[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_txb
        assign tx_busy[g] = (busy_cnt[g] != 0) || hold[g];
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 3; i++) begin
            prev_data[i] <= tx_data[i];
            prev_tb[i]   <= tx_busy[i];
            if (rst_n && tx_busy[i] && (tx_data[i] !== prev_data[i])) viol[i] <= viol[i] + 1;
            if (rdy[i] && tx_busy[i]) viol[i] <= viol[i] + 1;
            if (prev_tb[i] && !tx_busy[i]) fall_cyc[i] <= cyc;
            if (rdy[i] && !tx_busy[i]) begin
                if (rx_cnt[i] < 128) rx_mem[i][rx_cnt[i]] <= tx_data[i];
                rx_cnt[i]   <= rx_cnt[i] + 1;
                busy_cnt[i] <= 10;
            end else if (busy_cnt[i] != 0) begin
                busy_cnt[i] <= busy_cnt[i] - 1;
            end
            if (done[i]) begin
                done_cnt[i] <= done_cnt[i] + 1;
                if (cyc - fall_cyc[i] != 1) lat_err[i] <= lat_err[i] + 1;
            end
            if (clr) begin
                rx_cnt[i]   <= 0;
                done_cnt[i] <= 0;
            end
        end
    end

    task automatic check(input string tag, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
        end
    endtask

    task automatic clear();
        @(negedge clk) clr = 1'b1;
        @(negedge clk) clr = 1'b0;
    endtask

    task automatic start(input int i, input logic [255:0] d);
        @(negedge clk);
        digest = d;
        dv[i]  = 1'b1;
        @(negedge clk);
        dv[i]  = 1'b0;
    endtask

    task automatic wait_done(input int i, input string tag);
        int n = 0;
        while (done_cnt[i] == 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_seen"}, int'(done_cnt[i] != 0), 1);
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_rx(input int i, input int cnt, input string tag);
        int n = 0;
        while (rx_cnt[i] < cnt && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_rx_reached"}, int'(rx_cnt[i] >= cnt), 1);
    endtask

    task automatic compare_stream(input int i, input string exp, input string tag);
        int n;
        check({tag, "_len"}, rx_cnt[i], exp.len());
        n = (rx_cnt[i] < exp.len()) ? rx_cnt[i] : exp.len();
        if (n > 128) n = 128;
        for (int k = 0; k < n; k++) begin
            check($sformatf("%s_b%0d", tag, k), int'(rx_mem[i][k]), int'(exp[k]));
        end
    endtask

    initial begin
        string s_ones;
        string s_zeros;
        s_ones  = "";
        s_zeros = "";
        for (int k = 0; k < 64; k++) begin
            s_ones  = {s_ones, "f"};
            s_zeros = {s_zeros, "0"};
        end

        rst_n  = 1'b0;
        dv     = 3'b000;
        hold   = 3'b000;
        digest = '0;
        clr    = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_busy%0d", i), int'(busy[i]), 0);
            check($sformatf("rst_done%0d", i), int'(done[i]), 0);
            check($sformatf("rst_rdy%0d", i), int'(rdy[i]), 0);
            check($sformatf("rst_data%0d", i), int'(tx_data[i]), 0);
        end
        rst_n = 1'b1;
        clr   = 1'b0;

        // standard digest with CR/LF
        clear();
        start(0, DIG_D);
        check("std_first_rdy", int'(rdy[0]), 1);
        check("std_first_char", int'(tx_data[0]), 8'h33);
        check("std_busy_start", int'(busy[0]), 1);
        wait_done(0, "std");
        compare_stream(0, {HEX_D, "\r\n"}, "std");
        check("std_done_cnt", done_cnt[0], 1);
        check("std_busy_after", int'(busy[0]), 0);

        // all ones / all zeros, no CR/LF
        clear();
        start(1, {256{1'b1}});
        wait_done(1, "ones");
        compare_stream(1, s_ones, "ones");
        check("ones_done_cnt", done_cnt[1], 1);
        clear();
        start(1, '0);
        wait_done(1, "zeros");
        compare_stream(1, s_zeros, "zeros");
        check("zeros_done_cnt", done_cnt[1], 1);

        // start request during a transfer is ignored, digest change has no effect
        clear();
        start(0, DIG_D);
        wait_rx(0, 10, "ign");
        @(negedge clk);
        digest = ~DIG_D;
        dv[0]  = 1'b1;
        @(negedge clk);
        dv[0]  = 1'b0;
        check("ign_busy_mid", int'(busy[0]), 1);
        wait_done(0, "ign");
        compare_stream(0, {HEX_D, "\r\n"}, "ign");
        check("ign_done_cnt", done_cnt[0], 1);

        // uart already busy when the start is accepted
        clear();
        @(negedge clk) hold[0] = 1'b1;
        start(0, DIG_D);
        begin
            int rdy_hits = 0;
            for (int k = 0; k < 48; k++) begin
                @(negedge clk);
                if (rdy[0]) rdy_hits++;
            end
            check("stall_no_rdy", rdy_hits, 0);
        end
        check("stall_busy", int'(busy[0]), 1);
        hold[0] = 1'b0;
        #1;
        check("stall_release_rdy", int'(rdy[0]), 1);
        wait_done(0, "stall");
        compare_stream(0, {HEX_D, "\r\n"}, "stall");

        // reset in the middle of a transfer
        clear();
        start(0, DIG_D);
        wait_rx(0, 20, "rst");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", int'(busy[0]), 0);
        check("mid_rst_done", int'(done[0]), 0);
        check("mid_rst_rdy", int'(rdy[0]), 0);
        check("mid_rst_data", int'(tx_data[0]), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("mid_rst_no_done", done_cnt[0], 0);
        clear();
        start(0, DIG_D);
        wait_done(0, "post_rst");
        compare_stream(0, {HEX_D, "\r\n"}, "post_rst");
        check("post_rst_done_cnt", done_cnt[0], 1);

        // digest_valid held high: back-to-back transfers
        clear();
        @(negedge clk);
        digest = 256'ha5;
        dv[2]  = 1'b1;
        wait_rx(2, 12, "b2b");
        dv[2]  = 1'b0;
        begin
            int n = 0;
            while (busy[2] && n < 500) begin
                @(negedge clk);
                n++;
            end
            check("b2b_idle", int'(busy[2]), 0);
        end
        repeat (4) @(negedge clk);
        compare_stream(2, "a5\r\na5\r\na5\r\n", "b2b");
        check("b2b_done_cnt", done_cnt[2], 3);

        for (int i = 0; i < 3; i++) begin
            check($sformatf("protocol%0d", i), viol[i], 0);
            check($sformatf("done_latency%0d", i), lat_err[i], 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/digest_hex_tx.md
Name: digest_hex_tx

Overview:
- Converts a fixed-width hash digest from the SHA3 core into lowercase ASCII hex characters, then streams them one byte at a time into uart_tx.
- Sits between the SHA3 hash unit (upstream) and the UART simplex transmitter (downstream) on the A7 SHA3 hardware test.
- Output text matches the openssl digest format, so the result can be compared directly in a serial terminal.

Parameters:
- DIGEST_BITS, 256, digest width. Must be a multiple of 4 and at least 4.
- APPEND_CRLF, 1, when 1 append 8'h0d, 8'h0a after the hex digits; when 0 send hex digits only.

Ports:
- clk  input  1  system clock; same clock as uart_tx.
- rst_n  input  1  asynchronous active-low reset.
- digest  input  DIGEST_BITS  hash result; sampled only on an accepted start.
- digest_valid  input  1  start request. Accepted only in IDLE.
- busy  output  1  high from the accepted start until the end of the final character.
- done  output  1  one-cycle pulse after the last character completes.
- tx_data  output  8  ASCII byte; connects to uart_tx data.
- tx_data_ready  output  1  one-cycle request; connects to uart_tx data_ready.
- tx_busy  input  1  from uart_tx tx_busy.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: busy=0, done=0, tx_data_ready=0, tx_data=8'h00, state=IDLE, counter=0, shift register=0.
- Downstream contract with uart_tx:
  - uart_tx samples data_ready and data on a cycle where tx_busy=0.
  - It raises tx_busy on the following cycle and holds it until the stop bit ends.
- Character count N = DIGEST_BITS/4 + (APPEND_CRLF ? 2 : 0).
- Nibble order: most-significant nibble first.
- Nibble encoding: 0-9 map to 8'h30-8'h39; 10-15 map to 8'h61-8'h66 (lowercase).
- FSM states and transitions:
  - IDLE: if digest_valid=1, capture digest into an internal shift register, clear the counter, set busy=1, go to SEND.
  - SEND: wait until tx_busy=0. Then drive tx_data with the current character and assert tx_data_ready for exactly one cycle. Go to WAIT_HI.
  - WAIT_HI: wait for tx_busy=1. tx_data stays stable.
  - WAIT_LO: wait for tx_busy=0. Then:
    - if counter=N-1: set busy=0, pulse done, go to IDLE;
    - otherwise: increment the counter, shift the register left by 4 (only while hex characters remain), go to SEND.
  - After all hex characters, SEND emits 8'h0d and then 8'h0a when APPEND_CRLF=1.
- tx_data holds its last value between requests and is never changed while tx_busy=1.
- Boundary conditions:
  - digest_valid while busy=1: ignored, not queued. The captured digest is unaffected by later changes on the digest input.
  - digest_valid held high continuously: a new transfer starts on the first IDLE cycle after done. Back-to-back transfers are therefore allowed, with exactly one done per transfer.
  - tx_busy already high when a start is accepted: SEND stalls with tx_data_ready=0 until tx_busy=0.
  - rst_n asserted mid-transfer: immediately returns to IDLE with all outputs at reset values. The partial transfer is abandoned; no done pulse.
  - Counter width: clog2(N+1) bits. It must not wrap within a transfer.
- Latency:
  - accepted digest_valid to the first tx_data_ready: 1 cycle when tx_busy=0;
  - final tx_busy fall to done: 1 cycle.

Test Plan:
- Standard digest: with a uart_tx model (busy 10 cycles per byte), DIGEST_BITS=256, APPEND_CRLF=1, digest=256'h3a985da74fe225b2045c172d6bd390bd855f086e3e9d525b46bfe24511431532, one-cycle digest_valid -> exactly 66 bytes "3a985da7...11431532\r\n" in order, one done pulse, busy high throughout, busy=0 after.
- All-ones and all-zeros: digest=all 1s, APPEND_CRLF=0 -> 64 bytes of 8'h66 and no CR/LF. digest=0 -> 64 bytes of 8'h30.
- Ignored start: pulse digest_valid with a different digest during byte 10 -> output stream unchanged, exactly one done.
- Handshake stall: tx_busy forced high for 50 cycles at start -> no tx_data_ready until tx_busy=0. tx_data_ready is never high on a cycle where tx_busy=1. tx_data is stable while tx_busy=1.
- Reset mid-transfer: rst_n low after byte 20 -> outputs at reset values in the same cycle, no done. A new digest_valid then produces a full, correct 66-byte stream.
- Back-to-back: digest_valid held high with DIGEST_BITS=8, digest=8'hA5 -> repeated "a5\r\n" sequences, one done per 4 bytes.
